mem_arbiter: RTL and testbench

Sequencer and arbiter sharing the single external memory port (extmem/mainmem handshake: memadr, memrwb, membyteen, memen, memdone) between the instruction-cache refill path and the data-cache refill/write path. It grants one requester at a time with round-robin tie-breaking. Each grant runs as a line burst (reads) or a single word (data writes). A watchdog aborts transactions that the memory never acknowledges. It sits between the cache controller and external memory.

---
 rtl/mem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares the external memory port between instruction refills and data
// refills/writes: round-robin grant, line bursts with a gap cycle, watchdog.
module mem_arbiter #(
  parameter int  LINEWORDS = 4,
  parameter int  TIMEOUT   = 255,
  localparam int IDXW      = $clog2(LINEWORDS)
) (
  input  logic            ph1,
  input  logic            reset,
  input  logic            ireq,
  input  logic [26:0]     iadr,
  output logic [31:0]     irdata,
  output logic            ivalid,
  output logic [IDXW-1:0] iidx,
  output logic            idone,
  input  logic            dreq,
  input  logic            drwb,
  input  logic [26:0]     dadr,
  input  logic [31:0]     dwdata,
  input  logic [3:0]      dbyteen,
  output logic [31:0]     drdata,
  output logic            dvalid,
  output logic [IDXW-1:0] didx,
  output logic            ddone,
  output logic [26:0]     memadr,
  output logic [31:0]     memwdata,
  input  logic [31:0]     memrdata,
  output logic [3:0]      membyteen,
  output logic            memrwb,
  output logic            memen,
  input  logic            memdone,
  output logic            memerr,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_GAP, S_RELEASE} state_t;

  localparam logic [26:0]     LOWMASK = 27'(LINEWORDS - 1);
  localparam logic [IDXW-1:0] LASTIDX = IDXW'(LINEWORDS - 1);
  localparam logic [7:0]      TOLAST  = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            sideData_q, sideData_d;
  logic            lastData_q, lastData_d;
  logic [26:0]     base_q, base_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [26:0]     memadr_q, memadr_d;
  logic [31:0]     memwdata_q, memwdata_d;
  logic [3:0]      membyteen_q, membyteen_d;
  logic            memrwb_q, memrwb_d;
  logic            memen_q, memen_d;
  logic [31:0]     irdata_q, irdata_d, drdata_q, drdata_d;
  logic [IDXW-1:0] iidx_q, iidx_d, didx_q, didx_d;
  logic            ivalid_q, ivalid_d, dvalid_q, dvalid_d;
  logic            idone_q, idone_d, ddone_q, ddone_d;
  logic            memerr_q, memerr_d;
  logic            busy_q, busy_d;
  logic            grantData, reqRwb;
  logic [26:0]     reqAdr;

  // Every output comes straight from a register; reset drops any burst in flight.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sideData_q  <= 1'b0;
      lastData_q  <= 1'b0;
      base_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      memadr_q    <= '0;
      memwdata_q  <= '0;
      membyteen_q <= '0;
      memrwb_q    <= 1'b1;
      memen_q     <= 1'b0;
      irdata_q    <= '0;
      drdata_q    <= '0;
      iidx_q      <= '0;
      didx_q      <= '0;
      ivalid_q    <= 1'b0;
      dvalid_q    <= 1'b0;
      idone_q     <= 1'b0;
      ddone_q     <= 1'b0;
      memerr_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sideData_q  <= sideData_d;
      lastData_q  <= lastData_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      memadr_q    <= memadr_d;
      memwdata_q  <= memwdata_d;
      membyteen_q <= membyteen_d;
      memrwb_q    <= memrwb_d;
      memen_q     <= memen_d;
      irdata_q    <= irdata_d;
      drdata_q    <= drdata_d;
      iidx_q      <= iidx_d;
      didx_q      <= didx_d;
      ivalid_q    <= ivalid_d;
      dvalid_q    <= dvalid_d;
      idone_q     <= idone_d;
      ddone_q     <= ddone_d;
      memerr_q    <= memerr_d;
      busy_q      <= busy_d;
    end
  end

  // On a tie the side that was not served last wins.
  always_comb begin
    state_d     = state_q;
    sideData_d  = sideData_q;
    lastData_d  = lastData_q;
    base_d      = base_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    memadr_d    = memadr_q;
    memwdata_d  = memwdata_q;
    membyteen_d = membyteen_q;
    memrwb_d    = memrwb_q;
    memen_d     = 1'b0;
    irdata_d    = irdata_q;
    drdata_d    = drdata_q;
    iidx_d      = iidx_q;
    didx_d      = didx_q;
    ivalid_d    = 1'b0;
    dvalid_d    = 1'b0;
    idone_d     = 1'b0;
    ddone_d     = 1'b0;
    memerr_d    = memerr_q;
    grantData   = dreq && (!ireq || !lastData_q);
    reqRwb      = grantData ? drwb : 1'b1;
    reqAdr      = grantData ? dadr : iadr;

    case (state_q)
      S_IDLE: begin
        if (ireq || dreq) begin
          sideData_d  = grantData;
          lastData_d  = grantData;
          base_d      = reqRwb ? (reqAdr & ~LOWMASK) : reqAdr;
          idx_d       = '0;
          cnt_d       = '0;
          memadr_d    = base_d;
          memrwb_d    = reqRwb;
          membyteen_d = reqRwb ? 4'b1111 : dbyteen;
          memwdata_d  = grantData ? dwdata : memwdata_q;
          memen_d     = 1'b1;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (memdone) begin
          if (memrwb_q) begin
            if (sideData_q) begin
              drdata_d = memrdata;
              didx_d   = idx_q;
              dvalid_d = 1'b1;
            end else begin
              irdata_d = memrdata;
              iidx_d   = idx_q;
              ivalid_d = 1'b1;
            end
          end
          if (!memrwb_q || idx_q == LASTIDX) begin
            state_d = S_RELEASE;
            idone_d = !sideData_q;
            ddone_d = sideData_q;
          end else begin
            state_d = S_GAP;
          end
        end else if (cnt_q == TOLAST) begin
          state_d  = S_RELEASE;
          memerr_d = 1'b1;
          idone_d  = !sideData_q;
          ddone_d  = sideData_q;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          memen_d = 1'b1;
        end
      end
      // Base is line aligned, so adding the index never leaves the line.
      S_GAP: begin
        idx_d    = idx_q + IDXW'(1);
        memadr_d = base_q + 27'(idx_d);
        cnt_d    = '0;
        memen_d  = 1'b1;
        state_d  = S_ACCESS;
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign memadr    = memadr_q;
  assign memwdata  = memwdata_q;
  assign membyteen = membyteen_q;
  assign memrwb    = memrwb_q;
  assign memen     = memen_q;
  assign irdata    = irdata_q;
  assign drdata    = drdata_q;
  assign iidx      = iidx_q;
  assign didx      = didx_q;
  assign ivalid    = ivalid_q;
  assign dvalid    = dvalid_q;
  assign idone     = idone_q;
  assign ddone     = ddone_q;
  assign memerr    = memerr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts memory
// accesses and per-side responses; monitors compare what the DUT presents.
module tb_mem_arbiter;
  localparam int LW = 4;
  localparam int TO = 8;

  logic        ph1 = 1'b0;
  logic        reset;
  logic        ireq, dreq, drwb, memdone;
  logic [26:0] iadr, dadr, memadr;
  logic [31:0] irdata, drdata, dwdata, memwdata, memrdata;
  logic [3:0]  dbyteen, membyteen;
  logic [1:0]  iidx, didx;
  logic        ivalid, idone, dvalid, ddone, memrwb, memen, memerr, busy;

  mem_arbiter #(.LINEWORDS(LW), .TIMEOUT(TO)) dut (
    .ph1(ph1), .reset(reset),
    .ireq(ireq), .iadr(iadr), .irdata(irdata), .ivalid(ivalid), .iidx(iidx), .idone(idone),
    .dreq(dreq), .drwb(drwb), .dadr(dadr), .dwdata(dwdata), .dbyteen(dbyteen),
    .drdata(drdata), .dvalid(dvalid), .didx(didx), .ddone(ddone),
    .memadr(memadr), .memwdata(memwdata), .memrdata(memrdata), .membyteen(membyteen),
    .memrwb(memrwb), .memen(memen), .memdone(memdone), .memerr(memerr), .busy(busy)
  );

  always #5 ph1 = ~ph1;

  typedef struct {
    logic [26:0] adr;
    logic        rwb;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          len;
    int          gap;
  } acc_t;

  typedef struct {
    logic        isDone;
    logic [1:0]  idx;
    logic [31:0] data;
    logic        err;
    logic        withValid;
  } resp_t;

  acc_t  accQ[$];
  resp_t rq[2][$];
  int    tests = 0;
  int    fails = 0;
  int    fixedDelay = 0;
  logic  memStuck = 1'b0;
  logic  strayPulse = 1'b0;
  logic  errModel = 1'b0;
  logic  lastDataModel = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level prediction: what the memory port and requester should see.
  task automatic modelTxn(input logic side, input logic rwb, input logic [26:0] adr,
                          input logic [31:0] wdata, input logic [3:0] be, input int gapFirst);
    acc_t        a;
    resp_t       r;
    logic [26:0] base;
    int          nBeats;
    base   = rwb ? 27'((adr / 27'(LW)) * 27'(LW)) : adr;
    nBeats = (rwb && !memStuck) ? LW : 1;
    for (int k = 0; k < nBeats; k++) begin
      a.adr   = base + 27'(k);
      a.rwb   = rwb;
      a.be    = rwb ? 4'hF : be;
      a.wdata = wdata;
      a.len   = memStuck ? TO : ((fixedDelay >= 0) ? fixedDelay + 1 : 0);
      a.gap   = (k == 0) ? gapFirst : 1;
      accQ.push_back(a);
      if (rwb && !memStuck) begin
        r.isDone    = 1'b0;
        r.idx       = 2'(k);
        r.data      = {5'd0, a.adr} ^ 32'hA5A5A5A5;
        r.err       = 1'b0;
        r.withValid = 1'b0;
        rq[side].push_back(r);
      end
    end
    if (memStuck) errModel = 1'b1;
    r.isDone    = 1'b1;
    r.idx       = 2'd0;
    r.data      = 32'd0;
    r.err       = errModel;
    r.withValid = rwb && !memStuck;
    rq[side].push_back(r);
    lastDataModel = side;
  endtask

  task automatic waitDones(input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 200 * n) begin
      @(negedge ph1);
      cyc++;
      if (idone) seen++;
      if (ddone) seen++;
    end
    if (seen < n) checkOutput("done wait budget", 32'(seen), 32'(n));
  endtask

  task automatic applyStimulus(input logic side, input logic rwb, input logic [26:0] adr,
                               input logic [31:0] wdata, input logic [3:0] be);
    @(negedge ph1);
    modelTxn(side, rwb, adr, wdata, be, 0);
    if (side) begin
      dreq = 1'b1; drwb = rwb; dadr = adr; dwdata = wdata; dbyteen = be;
    end else begin
      ireq = 1'b1; iadr = adr;
    end
    waitDones(1);
    ireq = 1'b0;
    dreq = 1'b0;
  endtask

  task automatic runPair(input int n, input logic [26:0] ia, input logic rwb, input logic [26:0] da,
                         input logic [31:0] wd, input logic [3:0] be);
    logic side;
    @(negedge ph1);
    for (int t = 0; t < n; t++) begin
      side = !lastDataModel;
      modelTxn(side, side ? rwb : 1'b1, side ? da : ia, wd, be, (t == 0) ? 0 : 2);
    end
    ireq = 1'b1; iadr = ia;
    dreq = 1'b1; drwb = rwb; dadr = da; dwdata = wd; dbyteen = be;
    waitDones(n);
    ireq = 1'b0;
    dreq = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    accQ.delete();
    rq[0].delete();
    rq[1].delete();
    errModel = 1'b0;
    lastDataModel = 1'b0;
    repeat (2) @(negedge ph1);
    reset = 1'b0;
  endtask

  task automatic checkResp(input int s, input logic v, input logic [1:0] idx,
                           input logic [31:0] data, input logic done);
    resp_t e;
    string p;
    p = (s != 0) ? "d" : "i";
    if (v) begin
      if (rq[s].size() == 0) checkOutput({p, "valid unexpected"}, 32'(v), 32'd0);
      else if (rq[s][0].isDone) checkOutput({p, "valid beyond line"}, 32'(v), 32'd0);
      else begin
        e = rq[s].pop_front();
        checkOutput({p, "rdata"}, data, e.data);
        checkOutput({p, "idx"}, 32'(idx), 32'(e.idx));
      end
    end
    if (done) begin
      if (rq[s].size() == 0) checkOutput({p, "done unexpected"}, 32'(done), 32'd0);
      else begin
        e = rq[s].pop_front();
        checkOutput({p, "done early"}, 32'(done), 32'(e.isDone));
        if (e.isDone) begin
          checkOutput({p, "valid with done"}, 32'(v), 32'(e.withValid));
          checkOutput({p, "memerr at done"}, 32'(memerr), 32'(e.err));
          checkOutput({p, "busy at done"}, 32'(busy), 32'd1);
        end
      end
    end
  endtask

  // Response monitor.
  initial forever begin
    @(negedge ph1);
    if (!reset) begin
      checkResp(0, ivalid, iidx, irdata, idone);
      checkResp(1, dvalid, didx, drdata, ddone);
    end
  end

  // Memory-port monitor: one expected access per rising memen.
  logic accPrev = 1'b0;
  logic accHave = 1'b0;
  int   runLen = 0;
  int   lowRun = 0;
  acc_t cur;
  initial forever begin
    @(negedge ph1);
    if (reset) begin
      accPrev = 1'b0; accHave = 1'b0; runLen = 0; lowRun = 0;
    end else begin
      if (memen) begin
        if (!accPrev) begin
          runLen = 0;
          if (accQ.size() == 0) begin
            checkOutput("memen unexpected", 32'(memen), 32'd0);
            accHave = 1'b0;
          end else begin
            cur = accQ.pop_front();
            accHave = 1'b1;
            if (cur.gap > 0) checkOutput("memen low run", 32'(lowRun), 32'(cur.gap));
          end
        end
        runLen++;
        if (accHave) begin
          checkOutput("memadr", {5'd0, memadr}, {5'd0, cur.adr});
          checkOutput("memrwb", 32'(memrwb), 32'(cur.rwb));
          checkOutput("membyteen", 32'(membyteen), 32'(cur.be));
          if (!cur.rwb) checkOutput("memwdata", memwdata, cur.wdata);
        end
        lowRun = 0;
      end else begin
        if (accPrev && accHave && cur.len > 0) checkOutput("memen length", 32'(runLen), 32'(cur.len));
        if (accPrev) accHave = 1'b0;
        lowRun++;
      end
      accPrev = memen;
    end
  end

  // Memory model: answers each access after a delay; data is address-derived.
  int waitCnt = 0;
  int curDelay = 0;
  initial begin
    memdone = 1'b0;
    memrdata = 32'd0;
    forever begin
      @(negedge ph1);
      memdone = 1'b0;
      if (memen && !memStuck) begin
        if (waitCnt >= curDelay) begin
          memdone = 1'b1;
          memrdata = {5'd0, memadr} ^ 32'hA5A5A5A5;
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else if (!memen) begin
        waitCnt = 0;
        curDelay = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, 3));
        if (strayPulse) begin
          memdone = 1'b1;
          strayPulse = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global timeout: simulation still running, required to finish");
    $fatal(1, "[TB] timeout");
  end

  int          act;
  int          cyc;
  int          kind;
  logic [26:0] ra, rb;
  initial begin
    reset = 1'b1;
    ireq = 1'b0; iadr = '0; dreq = 1'b0; drwb = 1'b1; dadr = '0; dwdata = '0; dbyteen = '0;
    repeat (2) @(negedge ph1);
    checkOutput("reset memen", 32'(memen), 32'd0);
    checkOutput("reset ivalid", 32'(ivalid), 32'd0);
    checkOutput("reset dvalid", 32'(dvalid), 32'd0);
    checkOutput("reset idone", 32'(idone), 32'd0);
    checkOutput("reset ddone", 32'(ddone), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset memerr", 32'(memerr), 32'd0);
    checkOutput("reset memrwb", 32'(memrwb), 32'd1);
    checkOutput("reset memadr", {5'd0, memadr}, 32'd0);
    checkOutput("reset memwdata", memwdata, 32'd0);
    checkOutput("reset membyteen", 32'(membyteen), 32'd0);
    checkOutput("reset irdata", irdata, 32'd0);
    checkOutput("reset drdata", drdata, 32'd0);
    checkOutput("reset iidx", 32'(iidx), 32'd0);
    checkOutput("reset didx", 32'(didx), 32'd0);
    reset = 1'b0;

    fixedDelay = 0;
    applyStimulus(1'b0, 1'b1, 27'h0000013, 32'd0, 4'd0);
    fixedDelay = 3;
    applyStimulus(1'b1, 1'b0, 27'h40, 32'hDEADBEEF, 4'b0110);

    doReset();
    fixedDelay = 0;
    runPair(4, 27'h100, 1'b0, 27'h204, 32'h12345678, 4'hF);

    memStuck = 1'b1;
    applyStimulus(1'b0, 1'b1, 27'h300, 32'd0, 4'd0);
    memStuck = 1'b0;
    fixedDelay = -1;
    applyStimulus(1'b1, 1'b1, 27'h404, 32'd0, 4'd0);
    applyStimulus(1'b1, 1'b0, 27'h408, 32'hCAFEF00D, 4'b1001);
    doReset();
    checkOutput("memerr cleared by reset", 32'(memerr), 32'd0);

    // Reset while the burst sits in the gap after its second beat.
    fixedDelay = 0;
    @(negedge ph1);
    modelTxn(1'b0, 1'b1, 27'h520, 32'd0, 4'd0, 0);
    ireq = 1'b1; iadr = 27'h520;
    cyc = 0;
    while (!(ivalid && iidx == 2'd1) && cyc < 100) begin
      @(negedge ph1);
      cyc++;
    end
    checkOutput("beat 1 reached", 32'(iidx), 32'd1);
    ireq = 1'b0;
    #1 reset = 1'b1;
    #1;
    checkOutput("async reset memen", 32'(memen), 32'd0);
    checkOutput("async reset ivalid", 32'(ivalid), 32'd0);
    checkOutput("async reset idone", 32'(idone), 32'd0);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    doReset();
    act = 0;
    repeat (10) begin
      @(negedge ph1);
      act += int'(memen | ivalid | idone);
    end
    checkOutput("no beats after reset", 32'(act), 32'd0);
    applyStimulus(1'b0, 1'b1, 27'h520, 32'd0, 4'd0);

    @(negedge ph1);
    strayPulse = 1'b1;
    act = 0;
    repeat (4) begin
      @(negedge ph1);
      act += int'(ivalid | dvalid | memen | busy);
    end
    checkOutput("stray memdone ignored", 32'(act), 32'd0);

    fixedDelay = 1;
    @(negedge ph1);
    modelTxn(1'b0, 1'b1, 27'h777, 32'd0, 4'd0, 0);
    ireq = 1'b1; iadr = 27'h777;
    repeat (3) @(negedge ph1);
    ireq = 1'b0;
    repeat (2) @(negedge ph1);
    ireq = 1'b1;
    waitDones(1);
    ireq = 1'b0;

    fixedDelay = -1;
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 3));
      ra = 27'($urandom);
      rb = 27'($urandom);
      case (kind)
        0: applyStimulus(1'b0, 1'b1, ra, 32'd0, 4'd0);
        1: applyStimulus(1'b1, 1'b1, ra, 32'd0, 4'd0);
        2: applyStimulus(1'b1, 1'b0, ra, $urandom, 4'($urandom));
        default: runPair(int'($urandom_range(2, 4)), ra, 1'($urandom), rb, $urandom, 4'($urandom));
      endcase
      repeat ($urandom_range(0, 2)) @(negedge ph1);
    end

    repeat (5) @(negedge ph1);
    checkOutput("access queue drained", 32'(accQ.size()), 32'd0);
    checkOutput("i responses drained", 32'(rq[0].size()), 32'd0);
    checkOutput("d responses drained", 32'(rq[1].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
